finish_line_bank: RTL

//  Parametrised bank of NUM_SLOTS frog home slots on the top bank of the playfield.

---
 rtl/finish_line_bank.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/finish_line_bank.sv
`default_nettype none
// ============================================================================
// Module   : finish_line_bank
// Brief    : Bank of frog home slots. Flags slot pixels, latches filled slots
//            per frame, holds a celebration phase when all are full, then
//            pulses GoNextLevel. Optional feature macro: FINISH_BLOCKED_EN.
// Revision : 1.0
// ============================================================================
module finish_line_bank #(
  parameter int NUM_SLOTS   = 5,
  parameter int SLOT_X0     = 152,
  parameter int SLOT_PITCH  = 84,
  parameter int SLOT_Y      = 76,
  parameter int SLOT_SIZE   = 28,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_clk_rising_edge,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  input  logic                           is_frog,
  input  logic                           ResetGame,
  output logic [NUM_SLOTS-1:0]           isFinish,
  output logic [NUM_SLOTS-1:0]           FrogFinished,
  output logic [$clog2(NUM_SLOTS+1)-1:0] FillCount,
  output logic                           NewFill,
  output logic                           Celebrating,
  output logic                           GoNextLevel,
  output logic                           BlockedHit
);

  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [1:0] ST_PLAY      = 2'd0;
  localparam logic [1:0] ST_CELEBRATE = 2'd1;
  localparam logic [1:0] ST_ADVANCE   = 2'd2;

  localparam logic [NUM_SLOTS-1:0] C_ALL_FULL   = '1;
  localparam logic [HOLD_W-1:0]    C_HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0]    C_CNT_ONE    = HOLD_W'(1);
  localparam logic [10:0]          C_SLOT_TOP   = 11'(SLOT_Y);
  localparam logic [10:0]          C_SLOT_BOT   = 11'(SLOT_Y + SLOT_SIZE);

  logic [1:0]           r_state;
  logic [NUM_SLOTS-1:0] r_hitPend;
  logic [HOLD_W-1:0]    r_frameCnt;

  logic [10:0]          w_x;
  logic [10:0]          w_y;
  logic                 w_rowHit;
  logic [NUM_SLOTS-1:0] w_curHit;
  logic [NUM_SLOTS-1:0] w_newFill;
  logic [NUM_SLOTS-1:0] w_nextFinished;

  // Widen to 11 bits so the bounds compare never wraps.
  assign w_x      = {1'b0, DrawX};
  assign w_y      = {1'b0, DrawY};
  assign w_rowHit = (w_y >= C_SLOT_TOP) && (w_y < C_SLOT_BOT);

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      localparam logic [10:0] C_LEFT  = 11'(SLOT_X0 + i * SLOT_PITCH);
      localparam logic [10:0] C_RIGHT = 11'(SLOT_X0 + i * SLOT_PITCH + SLOT_SIZE);
      assign isFinish[i] = w_rowHit && (w_x >= C_LEFT) && (w_x < C_RIGHT);
    end
  endgenerate

  assign w_curHit       = is_frog ? isFinish : '0;
  assign w_newFill      = r_hitPend & ~FrogFinished;
  assign w_nextFinished = FrogFinished | w_newFill;

  assign Celebrating = (r_state == ST_CELEBRATE);
  assign GoNextLevel = (r_state == ST_ADVANCE);

  function automatic logic [CNT_W-1:0] popCount(input logic [NUM_SLOTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_PLAY;
      r_hitPend    <= '0;
      r_frameCnt   <= '0;
      FrogFinished <= '0;
      FillCount    <= '0;
      NewFill      <= 1'b0;
    end else if (ResetGame) begin
      r_state      <= ST_PLAY;
      r_hitPend    <= '0;
      r_frameCnt   <= '0;
      FrogFinished <= '0;
      FillCount    <= '0;
      NewFill      <= 1'b0;
    end else begin
      NewFill <= 1'b0;
      case (r_state)
        ST_PLAY: begin
          if (frame_clk_rising_edge) begin
            FrogFinished <= w_nextFinished;
            FillCount    <= popCount(w_nextFinished);
            NewFill      <= |w_newFill;
            if (w_nextFinished == C_ALL_FULL) begin
              r_state    <= ST_CELEBRATE;
              r_frameCnt <= C_HOLD_LOAD;
              r_hitPend  <= '0;
            end else begin
              // The edge-cycle pixel belongs to the frame that starts now.
              r_hitPend <= w_curHit;
            end
          end else begin
            r_hitPend <= r_hitPend | w_curHit;
          end
        end
        ST_CELEBRATE: begin
          if (frame_clk_rising_edge) begin
            if (r_frameCnt == C_CNT_ONE) begin
              r_state <= ST_ADVANCE;
            end else begin
              r_frameCnt <= r_frameCnt - C_CNT_ONE;
            end
          end
        end
        ST_ADVANCE: begin
          r_state      <= ST_PLAY;
          r_hitPend    <= '0;
          r_frameCnt   <= '0;
          FrogFinished <= '0;
          FillCount    <= '0;
        end
        default: begin
          r_state <= ST_PLAY;
        end
      endcase
    end
  end

`ifdef FINISH_BLOCKED_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      BlockedHit <= 1'b0;
    end else if (ResetGame) begin
      BlockedHit <= 1'b0;
    end else begin
      BlockedHit <= (r_state == ST_PLAY) && frame_clk_rising_edge &&
                    (|(r_hitPend & FrogFinished));
    end
  end
`else
  assign BlockedHit = 1'b0;
`endif

endmodule
`default_nettype wire
